mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported main memory (read/write/resp handshake, 32-bit word, byte enables)
//  between an instruction-fetch requester (read-only) and a data requester (read/write).
//  Sits between the CPU's two memory ports and the memory interface.
//  Latches one request, drives it stable to memory until resp, returns rdata/resp to the owner.
//  Inserts a mandatory idle cycle between transactions so memory sees a fresh read/write edge.
// PARAMETERS
//  RR_MODE         0  0 = fixed priority (data over instruction); 1 = round-robin on conflict
//  TIMEOUT_CYCLES  64 cycles in a SERVE state without mem_resp before err sets; 0 disables
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  i_read          in   1   instruction read request, held until i_resp
//  i_addr          in   32  instruction address
//  i_rdata         out  32  instruction read data, valid while i_resp=1
//  i_resp          out  1   one-cycle completion pulse to instruction port
//  d_read          in   1   data read request, held until d_resp
//  d_write         in   1   data write request, held until d_resp
//  d_addr          in   32  data address
//  d_wdata         in   32  data write data
//  d_byte_enable   in   4   data write byte enables
//  d_rdata         out  32  data read data, valid while d_resp=1
//  d_resp          out  1   one-cycle completion pulse to data port
//  mem_read        out  1   memory read strobe
//  mem_write       out  1   memory write strobe
//  mem_address     out  32  memory address
//  mem_wdata       out  32  memory write data
//  mem_byte_enable out  4   memory byte enables (4'b1111 on reads)
//  mem_rdata       in   32  memory read data, valid with mem_resp
//  mem_resp        in   1   memory completion, one cycle
//  err             out  1   sticky error: d_read&d_write together, or timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; rr pointer = data; timeout counter 0; err cleared.
//  - States: IDLE, SERVE_I, SERVE_D, RECOVER.
//  - IDLE: arbitrate on the current-cycle inputs. Only i -> SERVE_I; only d -> SERVE_D.
//    Both: RR_MODE=0 -> SERVE_D. RR_MODE=1 -> the port not granted last; pointer updates on grant.
//  - At grant edge: latch addr, wdata, byte_enable and op into registers.
//    Memory outputs come only from these registers; mem strobe is high in the first SERVE cycle
//    (one cycle after the request is seen in IDLE).
//  - SERVE_x: hold mem_read/mem_write, address, wdata and byte_enable constant every cycle.
//    Never assert mem_read and mem_write together. On mem_resp: capture mem_rdata and go to RECOVER.
//  - RECOVER (exactly 1 cycle): all mem strobes 0; owner's x_resp=1 with x_rdata = captured data.
//    The other port's resp stays 0. No arbitration in RECOVER. Next state IDLE.
//  - Latency: request seen at cycle t, mem_resp at cycle t+k (k>=1 after strobe)
//    -> x_resp at t+k+1 -> earliest next mem strobe at t+k+3.
//  - Requester rule: drop the request in the cycle after x_resp. Arbiter does not check it.
//  - x_rdata holds its last captured value outside resp. d_rdata on writes is don't-care (holds).
//  - d_read&d_write both high in IDLE: set err, grant neither data op, and still serve i_read
//    if present. This never occurs in SERVE because the ops are latched.
//  - Timeout: counter clears on grant and counts each SERVE cycle. At TIMEOUT_CYCLES set err.
//    Keep waiting; the transaction is not aborted.
//  - Reset mid-transaction: strobes drop the same edge, no resp emitted, pending op discarded.
//  - Address is passed through unaligned; memory aligns it.
// TESTING
//  1 Solo ifetch: i_read=1, i_addr=0x60 -> mem_read=1 one cycle later, mem_address=0x60 held;
//    mem_resp with 0xDEADBEEF -> i_resp pulse next cycle, i_rdata=0xDEADBEEF, d_resp stays 0.
//  2 Data write: d_write=1, addr 0x104, wdata 0x12345678, be=4'b0011 -> mem_write held with be=0011
//    until resp; d_resp once; mem_read never 1.
//  3 Conflict RR_MODE=0: i_read and d_read same cycle -> data served first, 1-cycle gap with both
//    strobes 0, then instruction served; both resps once, in that order.
//  4 Conflict RR_MODE=1: both requests held for 4 transactions -> grants alternate D,I,D,I.
//  5 Protocol error: d_read=d_write=1 in IDLE -> err=1 next cycle and stays 1; no mem_write issued.
//  6 Timeout=8, memory never responds -> err=1 after 8 SERVE cycles.
//    rst mid-SERVE -> all outputs 0 next cycle, no resp.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (ifetch/data) arbiter onto a single-ported memory with a latched request,
// one-cycle recovery gap between transactions, optional round-robin and a sticky error flag.
module mem_port_arbiter #(
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [31:0]         i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_enable,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [31:0]         mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

  state_t            state, state_nx;
  logic              grant_i, grant_d, dual_op, d_req;
  logic              serving, timeout_hit;
  logic              own_d_p1, rd_p1, wr_p1, rr_prio_d;
  logic [TW-1:0]     tcnt;
  logic [31:0]       addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [BE_W-1:0]   be_p1;
  logic [DATA_W-1:0] i_rdata_p2, d_rdata_p2;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TLIM) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    dual_op  = 1'b0;
    d_req    = 1'b0;
    case (state)
      IDLE: begin
        dual_op = d_read & d_write;
        d_req   = d_read ^ d_write;
        if (d_req && i_read) begin
          if (RR_MODE == 0 || rr_prio_d) grant_d = 1'b1;
          else                           grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end
        if (grant_d)      state_nx = SERVE_D;
        else if (grant_i) state_nx = SERVE_I;
      end
      SERVE_I, SERVE_D: if (mem_resp) state_nx = RECOVER;
      RECOVER:          state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  assign serving     = (state == SERVE_I) || (state == SERVE_D);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && serving && !mem_resp && (tcnt == TLIM);

  // p1: request latched at the grant edge; p2: read data captured on mem_resp
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      own_d_p1   <= 1'b0;
      rd_p1      <= 1'b0;
      wr_p1      <= 1'b0;
      rr_prio_d  <= 1'b1;
      tcnt       <= '0;
      err        <= 1'b0;
      i_rdata_p2 <= '0;
      d_rdata_p2 <= '0;
    end else begin
      state <= state_nx;
      if (grant_i || grant_d) begin
        own_d_p1  <= grant_d;
        rd_p1     <= grant_i | d_read;
        wr_p1     <= grant_d & d_write;
        rr_prio_d <= grant_i;
        tcnt      <= '0;
      end else if (serving && !mem_resp) begin
        tcnt <= sat_inc(tcnt);
      end
      if (dual_op || timeout_hit) err <= 1'b1;
      if (serving && mem_resp) begin
        if (!own_d_p1)  i_rdata_p2 <= mem_rdata;
        else if (rd_p1) d_rdata_p2 <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_i || grant_d) begin
      addr_p1  <= grant_d ? d_addr : i_addr;
      wdata_p1 <= grant_d ? d_wdata : '0;
      be_p1    <= (grant_d && d_write) ? d_byte_enable : '1;
    end
  end

  // Memory side is driven purely from latched state so it never glitches during SERVE
  assign mem_read        = serving & rd_p1;
  assign mem_write       = serving & wr_p1;
  assign mem_address     = serving ? addr_p1  : '0;
  assign mem_wdata       = serving ? wdata_p1 : '0;
  assign mem_byte_enable = serving ? be_p1    : '0;

  assign i_resp  = (state == RECOVER) & ~own_d_p1;
  assign d_resp  = (state == RECOVER) &  own_d_p1;
  assign i_rdata = i_rdata_p2;
  assign d_rdata = d_rdata_p2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: u0 is fixed priority, u1 round-robin, both timeout 8.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  d_be = '0;
  logic        mem_resp0 = 1'b0, mem_resp1 = 1'b0;

  logic [31:0] i_rdata0, d_rdata0, mem_address0, mem_wdata0;
  logic        i_resp0, d_resp0, mem_read0, mem_write0, err0;
  logic [3:0]  mem_be0;
  logic [31:0] i_rdata1, d_rdata1, mem_address1, mem_wdata1;
  logic        i_resp1, d_resp1, mem_read1, mem_write1, err1;
  logic [3:0]  mem_be1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_MODE(0), .TIMEOUT_CYCLES(8)) u0 (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata0), .i_resp(i_resp0),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_be), .d_rdata(d_rdata0), .d_resp(d_resp0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_address(mem_address0),
    .mem_wdata(mem_wdata0), .mem_byte_enable(mem_be0),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp0), .err(err0)
  );

  mem_port_arbiter #(.RR_MODE(1), .TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata1), .i_resp(i_resp1),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_be), .d_rdata(d_rdata1), .d_resp(d_resp1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_address(mem_address1),
    .mem_wdata(mem_wdata1), .mem_byte_enable(mem_be1),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    mem_resp0 = 1'b0; mem_resp1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk("rst_mem_read", mem_read0, 0);
    chk("rst_mem_write", mem_write0, 0);
    chk("rst_mem_address", mem_address0, 0);
    chk("rst_mem_be", mem_be0, 0);
    chk("rst_i_resp", i_resp0, 0);
    chk("rst_d_resp", d_resp0, 0);
    chk("rst_i_rdata", i_rdata0, 0);
    chk("rst_err", err0, 0);

    // solo instruction fetch
    i_read = 1'b1; i_addr = 32'h60;
    tick();
    chk("t1_mem_read", mem_read0, 1);
    chk("t1_mem_write", mem_write0, 0);
    chk("t1_addr", mem_address0, 32'h60);
    chk("t1_be", mem_be0, 4'hF);
    tick();
    chk("t1_read_held", mem_read0, 1);
    chk("t1_addr_held", mem_address0, 32'h60);
    mem_resp0 = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_resp0 = 1'b0; mem_rdata = '0; i_read = 1'b0;
    chk("t1_i_resp", i_resp0, 1);
    chk("t1_i_rdata", i_rdata0, 32'hDEADBEEF);
    chk("t1_d_resp", d_resp0, 0);
    chk("t1_recover_read", mem_read0, 0);
    tick();
    chk("t1_i_resp_pulse", i_resp0, 0);
    chk("t1_i_rdata_hold", i_rdata0, 32'hDEADBEEF);

    // data write
    d_write = 1'b1; d_addr = 32'h104; d_wdata = 32'h12345678; d_be = 4'b0011;
    tick();
    chk("t2_mem_write", mem_write0, 1);
    chk("t2_mem_read", mem_read0, 0);
    chk("t2_addr", mem_address0, 32'h104);
    chk("t2_wdata", mem_wdata0, 32'h12345678);
    chk("t2_be", mem_be0, 4'b0011);
    tick();
    chk("t2_write_held", mem_write0, 1);
    chk("t2_be_held", mem_be0, 4'b0011);
    chk("t2_mem_read_held", mem_read0, 0);
    mem_resp0 = 1'b1; mem_rdata = 32'hAAAA5555;
    tick();
    mem_resp0 = 1'b0; d_write = 1'b0;
    chk("t2_d_resp", d_resp0, 1);
    chk("t2_i_resp", i_resp0, 0);
    chk("t2_recover_write", mem_write0, 0);
    chk("t2_d_rdata_hold", d_rdata0, 0);
    tick();
    chk("t2_d_resp_pulse", d_resp0, 0);

    // fixed-priority conflict
    i_read = 1'b1; i_addr = 32'h200; d_read = 1'b1; d_addr = 32'h300;
    tick();
    chk("t3_first_read", mem_read0, 1);
    chk("t3_first_addr", mem_address0, 32'h300);
    mem_resp0 = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_resp0 = 1'b0; d_read = 1'b0;
    chk("t3_d_resp", d_resp0, 1);
    chk("t3_d_rdata", d_rdata0, 32'h11111111);
    chk("t3_i_resp_early", i_resp0, 0);
    tick();
    chk("t3_gap_read", mem_read0, 0);
    chk("t3_gap_write", mem_write0, 0);
    chk("t3_gap_d_resp", d_resp0, 0);
    tick();
    chk("t3_second_read", mem_read0, 1);
    chk("t3_second_addr", mem_address0, 32'h200);
    mem_resp0 = 1'b1; mem_rdata = 32'h22222222;
    tick();
    mem_resp0 = 1'b0; i_read = 1'b0;
    chk("t3_i_resp", i_resp0, 1);
    chk("t3_i_rdata", i_rdata0, 32'h22222222);
    chk("t3_d_resp_late", d_resp0, 0);
    tick();

    // round-robin with both requests held throughout
    do_reset();
    i_read = 1'b1; i_addr = 32'h400; d_read = 1'b1; d_addr = 32'h500;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t4_addr%0d", k), mem_address1, (k % 2 == 0) ? 32'h500 : 32'h400);
      chk($sformatf("t4_read%0d", k), mem_read1, 1);
      mem_resp1 = 1'b1; mem_rdata = 32'hC0DE0000 + k;
      tick();
      mem_resp1 = 1'b0;
      chk($sformatf("t4_d_resp%0d", k), d_resp1, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t4_i_resp%0d", k), i_resp1, (k % 2 == 0) ? 0 : 1);
      tick();
    end
    chk("t4_d_rdata", d_rdata1, 32'hC0DE0002);
    chk("t4_i_rdata", i_rdata1, 32'hC0DE0003);
    i_read = 1'b0; d_read = 1'b0;

    // illegal simultaneous data read and write
    do_reset();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h600;
    tick();
    chk("t5_err", err0, 1);
    chk("t5_no_write", mem_write0, 0);
    chk("t5_no_read", mem_read0, 0);
    d_read = 1'b0; d_write = 1'b0;
    tick();
    tick();
    chk("t5_err_sticky", err0, 1);
    chk("t5_still_no_write", mem_write0, 0);

    do_reset();
    chk("t5b_err_cleared", err0, 0);
    d_read = 1'b1; d_write = 1'b1; i_read = 1'b1; i_addr = 32'h700;
    tick();
    d_read = 1'b0; d_write = 1'b0;
    chk("t5b_err", err0, 1);
    chk("t5b_i_served", mem_read0, 1);
    chk("t5b_i_addr", mem_address0, 32'h700);
    chk("t5b_no_write", mem_write0, 0);
    mem_resp0 = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_resp0 = 1'b0; i_read = 1'b0;
    chk("t5b_i_resp", i_resp0, 1);
    chk("t5b_d_resp", d_resp0, 0);
    tick();

    // timeout, then reset mid-transaction
    do_reset();
    i_read = 1'b1; i_addr = 32'h80;
    tick();
    chk("t6_serve1_err", err0, 0);
    for (int c = 0; c < 7; c++) tick();
    chk("t6_serve8_err", err0, 0);
    tick();
    chk("t6_timeout_err", err0, 1);
    chk("t6_still_reading", mem_read0, 1);
    chk("t6_addr_held", mem_address0, 32'h80);
    rst = 1'b1; i_read = 1'b0;
    tick();
    chk("t6_rst_read", mem_read0, 0);
    chk("t6_rst_addr", mem_address0, 0);
    chk("t6_rst_i_resp", i_resp0, 0);
    chk("t6_rst_err", err0, 0);
    rst = 1'b0;
    tick();
    chk("t6_no_resp", i_resp0, 0);
    chk("t6_idle_read", mem_read0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
